// File: rtl/rv32i_pipe_follower.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pipe_follower
// Brief    : Shadow pipeline that mirrors RV32I fetch through WB under the
//            core's stall/flush control and checks retirement PC flow.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_pipe_follower #(
  parameter int              XLEN      = 32,
  parameter int              STAGES    = 6,
  parameter int              SEQW      = 8,
  parameter int              CHECK_PC0 = 0,
  parameter logic [XLEN-1:0] PC_INIT   = 'h200
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              if_valid_i,
  input  logic [31:0]       if_inst_i,
  input  logic [XLEN-1:0]   if_pc_i,
  input  logic [STAGES-1:0] stall_i,
  input  logic [STAGES-1:0] flush_i,
  input  logic [XLEN-1:0]   dut_wb_pc_i,
  output logic              wb_valid_o,
  output logic [31:0]       wb_inst_o,
  output logic [XLEN-1:0]   wb_pc_o,
  output logic [SEQW-1:0]   wb_seq_o,
  output logic              retire_o,
  output logic [31:0]       retire_cnt_o,
  output logic              pc_err_o,
  output logic              follow_err_o
);

  localparam logic [6:0]      c_op_jal    = 7'b1101111;
  localparam logic [6:0]      c_op_jalr   = 7'b1100111;
  localparam logic [6:0]      c_op_branch = 7'b1100011;
  localparam logic [31:0]     c_ecall     = 32'h0000_0073;
  localparam logic [31:0]     c_ebreak    = 32'h0010_0073;
  localparam logic [XLEN-1:0] c_four      = XLEN'(4);

  logic                w_slot_valid [STAGES];
  logic [31:0]         w_slot_inst  [STAGES];
  logic [XLEN-1:0]     w_slot_pc    [STAGES];
  logic [SEQW-1:0]     w_slot_seq   [STAGES];

  logic [SEQW-1:0]     r_seq;
  logic                w_if_load;

  assign w_if_load = ~flush_i[0] & ~stall_i[0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_seq <= '0;
    end else if (w_if_load && if_valid_i) begin
      r_seq <= r_seq + SEQW'(1);
    end
  end

  // Payload fields only move with a valid instruction so WB holds its last value.
  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic            r_valid;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_pc;
    logic [SEQW-1:0] r_seq_tag;

    if (k == 0) begin : g_if
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          r_valid   <= 1'b0;
          r_inst    <= '0;
          r_pc      <= '0;
          r_seq_tag <= '0;
        end else if (flush_i[k]) begin
          r_valid <= 1'b0;
        end else if (!stall_i[k]) begin
          r_valid <= if_valid_i;
          if (if_valid_i) begin
            r_inst    <= if_inst_i;
            r_pc      <= if_pc_i;
            r_seq_tag <= r_seq;
          end
        end
      end
    end else begin : g_tail
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          r_valid   <= 1'b0;
          r_inst    <= '0;
          r_pc      <= '0;
          r_seq_tag <= '0;
        end else if (flush_i[k]) begin
          r_valid <= 1'b0;
        end else if (!stall_i[k]) begin
          if (stall_i[k-1]) begin
            r_valid <= 1'b0;
          end else begin
            r_valid <= w_slot_valid[k-1];
            if (w_slot_valid[k-1]) begin
              r_inst    <= w_slot_inst[k-1];
              r_pc      <= w_slot_pc[k-1];
              r_seq_tag <= w_slot_seq[k-1];
            end
          end
        end
      end
    end

    assign w_slot_valid[k] = r_valid;
    assign w_slot_inst[k]  = r_inst;
    assign w_slot_pc[k]    = r_pc;
    assign w_slot_seq[k]   = r_seq_tag;
  end

  assign wb_valid_o = w_slot_valid[STAGES-1];
  assign wb_inst_o  = w_slot_inst[STAGES-1];
  assign wb_pc_o    = w_slot_pc[STAGES-1];
  assign wb_seq_o   = w_slot_seq[STAGES-1];
  assign retire_o   = wb_valid_o & ~stall_i[STAGES-1] & ~flush_i[STAGES-1];

  // Next-PC prediction for the retiring instruction.
  logic [6:0]      w_opcode;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_pc_seq;
  logic [XLEN-1:0] w_nxt_pc0;
  logic [XLEN-1:0] w_nxt_pc1;
  logic            w_nxt_known;

  assign w_opcode = wb_inst_o[6:0];
  assign w_imm_j  = {{(XLEN-21){wb_inst_o[31]}}, wb_inst_o[31], wb_inst_o[19:12],
                     wb_inst_o[20], wb_inst_o[30:21], 1'b0};
  assign w_imm_b  = {{(XLEN-13){wb_inst_o[31]}}, wb_inst_o[31], wb_inst_o[7],
                     wb_inst_o[30:25], wb_inst_o[11:8], 1'b0};
  assign w_pc_seq = wb_pc_o + c_four;

  always_comb begin
    w_nxt_pc0   = w_pc_seq;
    w_nxt_pc1   = w_pc_seq;
    w_nxt_known = 1'b1;
    if (w_opcode == c_op_jal) begin
      w_nxt_pc0 = wb_pc_o + w_imm_j;
      w_nxt_pc1 = wb_pc_o + w_imm_j;
    end else if (w_opcode == c_op_branch) begin
      w_nxt_pc1 = wb_pc_o + w_imm_b;
    end else if (w_opcode == c_op_jalr || wb_inst_o == c_ecall || wb_inst_o == c_ebreak) begin
      w_nxt_known = 1'b0;
    end
  end

  logic            r_exp_known;
  logic [XLEN-1:0] r_exp_pc0;
  logic [XLEN-1:0] r_exp_pc1;
  logic            r_pc_err;
  logic            r_follow_err;
  logic [31:0]     r_retire_cnt;

  // The check compares against the tracker state from before this retirement.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_exp_known <= (CHECK_PC0 != 0);
      r_exp_pc0   <= PC_INIT;
      r_exp_pc1   <= PC_INIT;
      r_pc_err    <= 1'b0;
    end else if (retire_o) begin
      r_exp_known <= w_nxt_known;
      r_exp_pc0   <= w_nxt_pc0;
      r_exp_pc1   <= w_nxt_pc1;
      if (r_exp_known && wb_pc_o != r_exp_pc0 && wb_pc_o != r_exp_pc1) begin
        r_pc_err <= 1'b1;
      end
    end else if (|flush_i) begin
      r_exp_known <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_follow_err <= 1'b0;
    end else if (wb_valid_o && wb_pc_o != dut_wb_pc_i) begin
      r_follow_err <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_retire_cnt <= '0;
    end else if (retire_o && r_retire_cnt != '1) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt_o = r_retire_cnt;
  assign pc_err_o     = r_pc_err;
  assign follow_err_o = r_follow_err;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_pipe_follower.sv
`default_nettype none
// Bench for rv32i_pipe_follower: scoreboarded retirement order plus PC-flow,
// follow-check and reset scenarios.
module tb_rv32i_pipe_follower;

  localparam logic [31:0] ADDI = 32'h0010_8093;
  localparam logic [31:0] BLT  = 32'h0420_C063;  // blt x1,x2,+0x40
  localparam logic [31:0] JAL  = 32'hFF9F_F06F;  // jal x0,-8
  localparam logic [31:0] JALR = 32'h0000_8067;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [5:0]  stall;
  logic [5:0]  flush;
  logic [31:0] dut_wb_pc;
  logic        wb_valid;
  logic [31:0] wb_inst;
  logic [31:0] wb_pc;
  logic [7:0]  wb_seq;
  logic        retire;
  logic [31:0] retire_cnt;
  logic        pc_err;
  logic        follow_err;

  rv32i_pipe_follower dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .if_valid_i(if_valid), .if_inst_i(if_inst), .if_pc_i(if_pc),
    .stall_i(stall), .flush_i(flush), .dut_wb_pc_i(dut_wb_pc),
    .wb_valid_o(wb_valid), .wb_inst_o(wb_inst), .wb_pc_o(wb_pc), .wb_seq_o(wb_seq),
    .retire_o(retire), .retire_cnt_o(retire_cnt),
    .pc_err_o(pc_err), .follow_err_o(follow_err)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  seq;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  tb_seq;
  logic [31:0] follow_off;

  assign dut_wb_pc = wb_pc + follow_off;

  // Drive one cycle of inputs; a fetch the IF slot will accept is recorded.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [5:0] st, input logic [5:0] fl);
    exp_t e;
    if_valid = v; if_inst = inst; if_pc = pc; stall = st; flush = fl;
    if (v && !st[0] && !fl[0]) begin
      e.pc = pc; e.inst = inst; e.seq = tb_seq;
      sb_q.push_back(e);
      tb_seq = tb_seq + 8'd1;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, 32'h0, 32'h0, 6'h0, 6'h0);
      tick();
    end
  endtask

  // Forget the expected PC via a flush with nothing retiring.
  task automatic unknown_pc();
    drive(1'b0, 32'h0, 32'h0, 6'h0, 6'b000001);
    tick();
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; follow_off = 32'h0; tb_seq = 8'd0;
    drive(1'b0, 32'h0, 32'h0, 6'h0, 6'h0);
    tick(); tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", wb_valid); end
    total++; if ({wb_inst, wb_pc, wb_seq} !== 72'h0) begin bad++; $display("FAIL reset_fields: got inst=%h pc=%h seq=%h want 0", wb_inst, wb_pc, wb_seq); end
    total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", retire_cnt); end
    total++; if ({pc_err, follow_err} !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", {pc_err, follow_err}); end
    HRESETn = 1'b1;
    sb_q.delete();
    tick();
  endtask

  task automatic test_stream();
    int   first = -1;
    int   last  = -1;
    int   nret  = 0;
    exp_t e;
    for (int i = 0; i < 14; i++) begin
      if (i < 6) drive(1'b1, ADDI, 32'h200 + 32'(4 * i), 6'h0, 6'h0);
      else       drive(1'b0, 32'h0, 32'h0, 6'h0, 6'h0);
      if (retire) begin
        if (first < 0) first = i;
        last = i; nret++;
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL stream_sb: retire with empty scoreboard pc=%h", wb_pc);
        end else begin
          e = sb_q.pop_front();
          if ({wb_pc, wb_inst, wb_seq} !== {e.pc, e.inst, e.seq}) begin
            bad++; $display("FAIL stream_sb: got pc=%h inst=%h seq=%0d want pc=%h inst=%h seq=%0d", wb_pc, wb_inst, wb_seq, e.pc, e.inst, e.seq);
          end
        end
      end
      tick();
    end
    total++; if (first != 6) begin bad++; $display("FAIL stream_latency: first retire at %0d want 6", first); end
    total++; if (nret != 6 || last != 11) begin bad++; $display("FAIL stream_consec: got %0d retires ending %0d want 6 ending 11", nret, last); end
    total++; if (retire_cnt !== 32'd6) begin bad++; $display("FAIL stream_cnt: got %0d want 6", retire_cnt); end
    total++; if ({pc_err, follow_err} !== 2'b00) begin bad++; $display("FAIL stream_err: got %b want 00", {pc_err, follow_err}); end
  endtask

  task automatic test_stall();
    int   first = -1;
    int   nret  = 0;
    exp_t e;
    sb_q.delete();
    for (int j = 0; j < 14; j++) begin
      if (j < 3)       drive(1'b1, ADDI, 32'h218 + 32'(4 * j), 6'h0, 6'h0);
      else if (j < 5)  drive(1'b0, 32'h0, 32'h0, 6'b000111, 6'h0);
      else             drive(1'b0, 32'h0, 32'h0, 6'h0, 6'h0);
      if (retire) begin
        if (first < 0) first = j;
        nret++;
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL stall_sb: retire with empty scoreboard pc=%h", wb_pc);
        end else begin
          e = sb_q.pop_front();
          if ({wb_pc, wb_inst, wb_seq} !== {e.pc, e.inst, e.seq}) begin
            bad++; $display("FAIL stall_sb: got pc=%h seq=%0d want pc=%h seq=%0d", wb_pc, wb_seq, e.pc, e.seq);
          end
        end
      end
      tick();
    end
    total++; if (first != 8) begin bad++; $display("FAIL stall_bubbles: first retire at %0d want 8", first); end
    total++; if (nret != 3) begin bad++; $display("FAIL stall_count: got %0d want 3", nret); end
    total++; if (retire_cnt !== 32'd9) begin bad++; $display("FAIL stall_cnt: got %0d want 9", retire_cnt); end
  endtask

  task automatic test_branch_ok();
    unknown_pc();
    drive(1'b1, BLT, 32'h300, 6'h0, 6'h0);  tick();
    drive(1'b1, ADDI, 32'h340, 6'h0, 6'h0); tick();
    idle(8);
    total++; if (pc_err !== 1'b0) begin bad++; $display("FAIL branch_taken: pc_err got %b want 0", pc_err); end
    unknown_pc();
    drive(1'b1, BLT, 32'h300, 6'h0, 6'h0);  tick();
    drive(1'b1, ADDI, 32'h304, 6'h0, 6'h0); tick();
    idle(8);
    total++; if (pc_err !== 1'b0) begin bad++; $display("FAIL branch_not_taken: pc_err got %b want 0", pc_err); end
    total++; if (retire_cnt !== 32'd13) begin bad++; $display("FAIL branch_cnt: got %0d want 13", retire_cnt); end
  endtask

  task automatic test_jal();
    logic hit = 1'b0;
    unknown_pc();
    drive(1'b1, JAL, 32'h400, 6'h0, 6'h0);  tick();
    drive(1'b1, ADDI, 32'h3F8, 6'h0, 6'h0); tick();
    drive(1'b1, JALR, 32'h3FC, 6'h0, 6'h0); tick();
    for (int c = 0; c < 20; c++) begin
      if (!hit && wb_valid && wb_pc == 32'h3FC) begin
        hit = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 6'h0, 6'h3F);
      end else begin
        drive(1'b0, 32'h0, 32'h0, 6'h0, 6'h0);
      end
      tick();
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL jal_wait: JALR never reached WB (timeout) got %b want 1", hit); end
    total++; if (pc_err !== 1'b0) begin bad++; $display("FAIL jal_target: pc_err got %b want 0", pc_err); end
    drive(1'b1, ADDI, 32'h1000, 6'h0, 6'h0); tick();
    idle(8);
    total++; if (pc_err !== 1'b0) begin bad++; $display("FAIL flush_unknown: pc_err got %b want 0", pc_err); end
    total++; if (retire_cnt !== 32'd16) begin bad++; $display("FAIL jal_cnt: got %0d want 16", retire_cnt); end
  endtask

  task automatic test_branch_err();
    unknown_pc();
    drive(1'b1, BLT, 32'h300, 6'h0, 6'h0);  tick();
    drive(1'b1, ADDI, 32'h308, 6'h0, 6'h0); tick();
    idle(8);
    total++; if (pc_err !== 1'b1) begin bad++; $display("FAIL branch_bad: pc_err got %b want 1", pc_err); end
    total++; if (follow_err !== 1'b0) begin bad++; $display("FAIL branch_follow: follow_err got %b want 0", follow_err); end
  endtask

  task automatic test_follow();
    logic seen = 1'b0;
    follow_off = 32'h4;
    drive(1'b1, ADDI, 32'h500, 6'h0, 6'h0); tick();
    for (int c = 0; c < 20 && !seen; c++) begin
      drive(1'b0, 32'h0, 32'h0, 6'h0, 6'h0);
      if (wb_valid) begin
        seen = 1'b1;
        total++; if (follow_err !== 1'b0) begin bad++; $display("FAIL follow_early: got %b want 0", follow_err); end
      end
      tick();
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL follow_wait: WB never valid (timeout) got %b want 1", seen); end
    total++; if (follow_err !== 1'b1) begin bad++; $display("FAIL follow_set: got %b want 1", follow_err); end
    follow_off = 32'h0;
    idle(8);
    total++; if (follow_err !== 1'b1) begin bad++; $display("FAIL follow_sticky: got %b want 1", follow_err); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ADDI, 32'h600 + 32'(4 * i), 6'h0, 6'h0);
      tick();
    end
    total++; if ({wb_valid, pc_err, follow_err} !== 3'b111) begin bad++; $display("FAIL mid_pre: got %b want 111", {wb_valid, pc_err, follow_err}); end
    #2 HRESETn = 1'b0;
    #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", wb_valid); end
    total++; if ({pc_err, follow_err} !== 2'b00) begin bad++; $display("FAIL mid_err: got %b want 00", {pc_err, follow_err}); end
    total++; if (wb_seq !== 8'd0) begin bad++; $display("FAIL mid_seq: got %0d want 0", wb_seq); end
    drive(1'b0, 32'h0, 32'h0, 6'h0, 6'h0);
    tick();
    HRESETn = 1'b1; tb_seq = 8'd0;
    sb_q.delete();
    idle(8);
    total++; if (wb_valid !== 1'b0 || retire_cnt !== 32'd0) begin bad++; $display("FAIL mid_discard: valid=%b cnt=%0d want 0 0", wb_valid, retire_cnt); end
  endtask

  task automatic test_back_to_back();
    int   idx = 0;
    int   nret = 0;
    exp_t e;
    logic [5:0] st;
    for (int c = 0; c < 2000 && (idx < 260 || sb_q.size() != 0); c++) begin
      st = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'h0;
      if (idx < 260) begin
        drive(1'b1, ADDI, 32'h200 + 32'(4 * idx), st, 6'h0);
        if (st == 6'h0) idx++;
      end else begin
        drive(1'b0, 32'h0, 32'h0, st, 6'h0);
      end
      if (retire) begin
        nret++;
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL b2b_sb: retire with empty scoreboard pc=%h", wb_pc);
        end else begin
          e = sb_q.pop_front();
          if ({wb_pc, wb_inst, wb_seq} !== {e.pc, e.inst, e.seq}) begin
            bad++; $display("FAIL b2b_sb: got pc=%h seq=%0d want pc=%h seq=%0d", wb_pc, wb_seq, e.pc, e.seq);
          end
        end
      end
      tick();
    end
    total++; if (sb_q.size() != 0 || nret != 260) begin bad++; $display("FAIL b2b_drain: retired %0d left %0d want 260 0", nret, sb_q.size()); end
    total++; if (retire_cnt !== 32'd260) begin bad++; $display("FAIL b2b_cnt: got %0d want 260", retire_cnt); end
    total++; if (wb_seq !== 8'd3) begin bad++; $display("FAIL b2b_seq_wrap: got %0d want 3", wb_seq); end
    total++; if ({pc_err, follow_err} !== 2'b00) begin bad++; $display("FAIL b2b_err: got %b want 00", {pc_err, follow_err}); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_ok();
    test_jal();
    test_branch_err();
    test_follow();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
